// File: rtl/seven_seg_scan_mux.sv
// Time-multiplexed driver for an N-digit seven-segment display.
// Hex values and decimal points are latched on load, then one digit is lit per prescaler slot, with a dark gap at the start of each slot.
module seven_seg_scan_mux #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 100000,
    parameter int BLANK_CYCLES   = 16,
    parameter int LZ_SUPPRESS    = 0,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int SEL_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    frame_done
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [6:0]            SEG_INV = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_INV  = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] SEL_INV = (SEL_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;

    logic [CW-1:0]           cnt_reg;
    logic [IW-1:0]           idx_reg;
    logic [4*NUM_DIGITS-1:0] shadow_val_reg;
    logic [NUM_DIGITS-1:0]   shadow_dp_reg;
    logic [6:0]              seg_reg;
    logic                    dp_reg;
    logic [NUM_DIGITS-1:0]   sel_reg;
    logic                    frame_done_reg;

    logic [3:0]            nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] dark;
    logic [3:0]            cur_nib;
    logic [6:0]            hex_code;
    logic [6:0]            seg_next;
    logic                  dp_next;
    logic [NUM_DIGITS-1:0] sel_next;
    logic                  cnt_last;
    logic                  idx_last;
    logic                  in_gap;

    // A digit above 0 goes dark when it and every more significant nibble are zero.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign nib[gi] = shadow_val_reg[4*gi +: 4];
            if (gi == 0) begin : g_lsd
                assign dark[gi] = 1'b0;
            end else begin : g_upper
                assign dark[gi] = (LZ_SUPPRESS != 0) && ~|shadow_val_reg[4*NUM_DIGITS-1:4*gi];
            end
        end
    endgenerate

    assign cnt_last = (cnt_reg == CW'(REFRESH_DIV - 1));
    assign idx_last = (idx_reg == IW'(NUM_DIGITS - 1));
    assign in_gap   = (32'(cnt_reg) < BLANK_CYCLES);
    assign cur_nib  = nib[idx_reg];

    always_comb begin
        hex_code = 7'h00;
        case (cur_nib)
            4'h0: hex_code = 7'h3F;
            4'h1: hex_code = 7'h06;
            4'h2: hex_code = 7'h5B;
            4'h3: hex_code = 7'h4F;
            4'h4: hex_code = 7'h66;
            4'h5: hex_code = 7'h6D;
            4'h6: hex_code = 7'h7D;
            4'h7: hex_code = 7'h07;
            4'h8: hex_code = 7'h7F;
            4'h9: hex_code = 7'h6F;
            4'hA: hex_code = 7'h77;
            4'hB: hex_code = 7'h7C;
            4'hC: hex_code = 7'h39;
            4'hD: hex_code = 7'h5E;
            4'hE: hex_code = 7'h79;
            4'hF: hex_code = 7'h71;
            default: hex_code = 7'h00;
        endcase
    end

    // Next pin levels in active-high sense, then folded to board polarity.
    always_comb begin
        seg_next = hex_code;
        if (in_gap || blank || dark[idx_reg]) begin
            seg_next = 7'h00;
        end
        dp_next  = ~(in_gap | blank) & shadow_dp_reg[idx_reg];
        sel_next = in_gap ? '0 : (NUM_DIGITS'(1) << idx_reg);
        seg_next = seg_next ^ SEG_INV;
        dp_next  = dp_next ^ DP_INV;
        sel_next = sel_next ^ SEL_INV;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg        <= '0;
            idx_reg        <= '0;
            shadow_val_reg <= '0;
            shadow_dp_reg  <= '0;
            seg_reg        <= SEG_INV;
            dp_reg         <= DP_INV;
            sel_reg        <= SEL_INV;
            frame_done_reg <= 1'b0;
        end else begin
            if (cnt_last) begin
                cnt_reg <= '0;
                idx_reg <= idx_last ? '0 : idx_reg + 1'b1;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            if (load) begin
                shadow_val_reg <= value_in;
                shadow_dp_reg  <= dp_in;
            end
            seg_reg        <= seg_next;
            dp_reg         <= dp_next;
            sel_reg        <= sel_next;
            frame_done_reg <= cnt_last && idx_last;
        end
    end

    assign seg        = seg_reg;
    assign dp         = dp_reg;
    assign dig_sel    = sel_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seven_seg_scan_mux.sv
// Directed bench for seven_seg_scan_mux: three instances (plain, leading-zero suppression, active-low pins)
// share one stimulus stream and are checked against hand-derived scan positions and segment codes.
module tb_seven_seg_scan_mux;
    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic        blank;
    logic [15:0] value_in;
    logic [3:0]  dp_in;

    logic [6:0] seg_a, seg_z, seg_l;
    logic       dp_a, dp_z, dp_l;
    logic [3:0] sel_a, sel_z, sel_l;
    logic       fd_a, fd_z, fd_l;

    int total = 0;
    int bad   = 0;
    int edges = 0;

    always #5 clk = ~clk;

    seven_seg_scan_mux #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1), .LZ_SUPPRESS(0),
                         .SEG_ACTIVE_LOW(0), .SEL_ACTIVE_LOW(0)) u_dut (
        .clk(clk), .rst(rst), .load(load), .value_in(value_in), .dp_in(dp_in), .blank(blank),
        .seg(seg_a), .dp(dp_a), .dig_sel(sel_a), .frame_done(fd_a));

    seven_seg_scan_mux #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1), .LZ_SUPPRESS(1),
                         .SEG_ACTIVE_LOW(0), .SEL_ACTIVE_LOW(0)) u_lz (
        .clk(clk), .rst(rst), .load(load), .value_in(value_in), .dp_in(dp_in), .blank(blank),
        .seg(seg_z), .dp(dp_z), .dig_sel(sel_z), .frame_done(fd_z));

    seven_seg_scan_mux #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1), .LZ_SUPPRESS(0),
                         .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)) u_low (
        .clk(clk), .rst(rst), .load(load), .value_in(value_in), .dp_in(dp_in), .blank(blank),
        .seg(seg_l), .dp(dp_l), .dig_sel(sel_l), .frame_done(fd_l));

    function automatic logic [6:0] hexseg(input logic [3:0] v);
        case (v)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    // Advance n rising edges, then settle on the falling edge for sampling/driving.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            edges++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; load = 1'b0; blank = 1'b0; value_in = 16'h0; dp_in = 4'h0;
        tick(2);
        total++; if (seg_a !== 7'h00) begin bad++; $display("FAIL reset_seg got=%h want=00", seg_a); end
        total++; if (dp_a !== 1'b0) begin bad++; $display("FAIL reset_dp got=%b want=0", dp_a); end
        total++; if (sel_a !== 4'h0) begin bad++; $display("FAIL reset_sel got=%b want=0000", sel_a); end
        total++; if (fd_a !== 1'b0) begin bad++; $display("FAIL reset_fd got=%b want=0", fd_a); end
        total++; if (seg_l !== 7'h7F) begin bad++; $display("FAIL reset_seg_low got=%h want=7f", seg_l); end
        total++; if (dp_l !== 1'b1) begin bad++; $display("FAIL reset_dp_low got=%b want=1", dp_l); end
        total++; if (sel_l !== 4'hF) begin bad++; $display("FAIL reset_sel_low got=%b want=1111", sel_l); end
        $display("reset: seg=%h dp=%b sel=%b fd=%b", seg_a, dp_a, sel_a, fd_a);
        rst = 1'b0;
        edges = 0;
    endtask

    task automatic test_scan;
        logic [15:0] v;
        int ph, cnt, idx;
        logic [6:0] es;
        logic [3:0] esel;
        logic efd;
        v = 16'h1A3F;
        value_in = v; dp_in = 4'h0; load = 1'b1;
        tick(1);
        load = 1'b0;
        total++; if (sel_a !== 4'h0) begin bad++; $display("FAIL scan_first_gap got=%b want=0000", sel_a); end
        tick(1);
        for (int k = 0; k < 32; k++) begin
            ph = edges - 1; cnt = ph % 4; idx = (ph / 4) % 4;
            es   = (cnt == 0) ? 7'h00 : hexseg(v[idx*4 +: 4]);
            esel = (cnt == 0) ? 4'h0 : (4'h1 << idx);
            efd  = ((ph % 16) == 15);
            total++; if (sel_a !== esel) begin bad++; $display("FAIL scan_sel e=%0d got=%b want=%b", edges, sel_a, esel); end
            total++; if (seg_a !== es) begin bad++; $display("FAIL scan_seg e=%0d got=%h want=%h", edges, seg_a, es); end
            total++; if (fd_a !== efd) begin bad++; $display("FAIL scan_fd e=%0d got=%b want=%b", edges, fd_a, efd); end
            total++; if (seg_z !== es) begin bad++; $display("FAIL scan_seg_lz e=%0d got=%h want=%h", edges, seg_z, es); end
            total++; if (sel_l !== ~esel) begin bad++; $display("FAIL scan_sel_low e=%0d got=%b want=%b", edges, sel_l, ~esel); end
            total++; if (seg_l !== ~es) begin bad++; $display("FAIL scan_seg_low e=%0d got=%h want=%h", edges, seg_l, ~es); end
            $display("scan: e=%0d cnt=%0d idx=%0d sel=%b seg=%h fd=%b", edges, cnt, idx, sel_a, seg_a, fd_a);
            tick(1);
        end
    endtask

    task automatic test_lz;
        logic [15:0] v;
        logic [6:0]  ez [4];
        int ph, cnt, idx;
        logic [6:0] es, ea;
        logic [3:0] esel;
        for (int p = 0; p < 3; p++) begin
            case (p)
                0: begin v = 16'h0005; ez[0] = 7'h6D; ez[1] = 7'h00; ez[2] = 7'h00; ez[3] = 7'h00; end
                1: begin v = 16'h0305; ez[0] = 7'h6D; ez[1] = 7'h3F; ez[2] = 7'h4F; ez[3] = 7'h00; end
                default: begin v = 16'h0000; ez[0] = 7'h3F; ez[1] = 7'h00; ez[2] = 7'h00; ez[3] = 7'h00; end
            endcase
            // back-to-back loads: only the second value may survive
            value_in = 16'h1111; load = 1'b1;
            tick(1);
            value_in = v;
            tick(1);
            load = 1'b0;
            tick(1);
            for (int k = 0; k < 16; k++) begin
                ph = edges - 1; cnt = ph % 4; idx = (ph / 4) % 4;
                es   = (cnt == 0) ? 7'h00 : ez[idx];
                ea   = (cnt == 0) ? 7'h00 : hexseg(v[idx*4 +: 4]);
                esel = (cnt == 0) ? 4'h0 : (4'h1 << idx);
                total++; if (seg_z !== es) begin bad++; $display("FAIL lz_seg v=%h idx=%0d got=%h want=%h", v, idx, seg_z, es); end
                total++; if (sel_z !== esel) begin bad++; $display("FAIL lz_sel v=%h got=%b want=%b", v, sel_z, esel); end
                total++; if (seg_a !== ea) begin bad++; $display("FAIL lz_off_seg v=%h idx=%0d got=%h want=%h", v, idx, seg_a, ea); end
                $display("lz: v=%h idx=%0d cnt=%0d sel=%b seg=%h", v, idx, cnt, sel_z, seg_z);
                tick(1);
            end
        end
    endtask

    task automatic test_load_wrap;
        value_in = 16'h1A3F; load = 1'b1;
        tick(1);
        load = 1'b0;
        while ((edges % 16) != 7) tick(1);
        value_in = 16'h1C5F; load = 1'b1;
        tick(1);
        load = 1'b0;
        total++; if (sel_a !== 4'b0010) begin bad++; $display("FAIL wrap_sel_d1 got=%b want=0010", sel_a); end
        total++; if (seg_a !== 7'h4F) begin bad++; $display("FAIL wrap_old_d1 got=%h want=4f", seg_a); end
        $display("wrap: load edge sel=%b seg=%h", sel_a, seg_a);
        tick(1);
        total++; if (sel_a !== 4'b0000) begin bad++; $display("FAIL wrap_gap got=%b want=0000", sel_a); end
        total++; if (seg_a !== 7'h00) begin bad++; $display("FAIL wrap_gap_seg got=%h want=00", seg_a); end
        $display("wrap: +1 sel=%b seg=%h", sel_a, seg_a);
        tick(1);
        total++; if (sel_a !== 4'b0100) begin bad++; $display("FAIL wrap_sel_d2 got=%b want=0100", sel_a); end
        total++; if (seg_a !== 7'h39) begin bad++; $display("FAIL wrap_new_d2 got=%h want=39", seg_a); end
        $display("wrap: +2 sel=%b seg=%h", sel_a, seg_a);
        tick(6);
        total++; if (sel_a !== 4'b1000 || seg_a !== 7'h06) begin
            bad++; $display("FAIL wrap_d3 got=%b/%h want=1000/06", sel_a, seg_a);
        end
        $display("wrap: d3 sel=%b seg=%h", sel_a, seg_a);
    endtask

    task automatic test_blank;
        logic [15:0] v;
        int ph, cnt, idx;
        logic [3:0] esel;
        logic [6:0] es;
        v = 16'h1C5F;
        value_in = v; dp_in = 4'hF; load = 1'b1;
        tick(1);
        load = 1'b0;
        tick(3);
        blank = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            ph = edges - 1; cnt = ph % 4; idx = (ph / 4) % 4;
            esel = (cnt == 0) ? 4'h0 : (4'h1 << idx);
            total++; if (seg_a !== 7'h00) begin bad++; $display("FAIL blank_seg got=%h want=00", seg_a); end
            total++; if (dp_a !== 1'b0) begin bad++; $display("FAIL blank_dp got=%b want=0", dp_a); end
            total++; if (sel_a !== esel) begin bad++; $display("FAIL blank_sel got=%b want=%b", sel_a, esel); end
            $display("blank: idx=%0d cnt=%0d sel=%b seg=%h dp=%b", idx, cnt, sel_a, seg_a, dp_a);
        end
        blank = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick(1);
            ph = edges - 1; cnt = ph % 4; idx = (ph / 4) % 4;
            esel = (cnt == 0) ? 4'h0 : (4'h1 << idx);
            es   = (cnt == 0) ? 7'h00 : hexseg(v[idx*4 +: 4]);
            total++; if (seg_a !== es) begin bad++; $display("FAIL unblank_seg got=%h want=%h", seg_a, es); end
            total++; if (dp_a !== (cnt != 0)) begin bad++; $display("FAIL unblank_dp got=%b want=%b", dp_a, cnt != 0); end
            total++; if (sel_a !== esel) begin bad++; $display("FAIL unblank_sel got=%b want=%b", sel_a, esel); end
            $display("unblank: idx=%0d cnt=%0d sel=%b seg=%h dp=%b", idx, cnt, sel_a, seg_a, dp_a);
        end
    endtask

    task automatic test_active_low;
        int ph, cnt, idx;
        value_in = 16'h8888; dp_in = 4'hF; load = 1'b1;
        tick(1);
        load = 1'b0;
        tick(1);
        for (int k = 0; k < 16; k++) begin
            ph = edges - 1; cnt = ph % 4; idx = (ph / 4) % 4;
            if (cnt == 0) begin
                total++; if (sel_l !== 4'hF) begin bad++; $display("FAIL low_gap_sel got=%b want=1111", sel_l); end
                total++; if (seg_l !== 7'h7F) begin bad++; $display("FAIL low_gap_seg got=%h want=7f", seg_l); end
                total++; if (dp_l !== 1'b1) begin bad++; $display("FAIL low_gap_dp got=%b want=1", dp_l); end
            end else begin
                total++; if (sel_l !== ~(4'h1 << idx)) begin bad++; $display("FAIL low_sel got=%b want=%b", sel_l, ~(4'h1 << idx)); end
                total++; if (seg_l !== 7'h00) begin bad++; $display("FAIL low_seg got=%h want=00", seg_l); end
                total++; if (dp_l !== 1'b0) begin bad++; $display("FAIL low_dp got=%b want=0", dp_l); end
            end
            $display("low: idx=%0d cnt=%0d sel=%b seg=%h dp=%b", idx, cnt, sel_l, seg_l, dp_l);
            tick(1);
        end
    endtask

    task automatic test_reset_mid;
        int ph, cnt, idx;
        logic [3:0] esel;
        logic [6:0] es;
        while ((edges % 16) != 10) tick(1);
        rst = 1'b1;
        tick(1);
        total++; if (sel_a !== 4'h0) begin bad++; $display("FAIL rmid_sel got=%b want=0000", sel_a); end
        total++; if (seg_a !== 7'h00) begin bad++; $display("FAIL rmid_seg got=%h want=00", seg_a); end
        total++; if (fd_a !== 1'b0) begin bad++; $display("FAIL rmid_fd got=%b want=0", fd_a); end
        total++; if (sel_l !== 4'hF) begin bad++; $display("FAIL rmid_sel_low got=%b want=1111", sel_l); end
        $display("reset_mid: sel=%b seg=%h fd=%b", sel_a, seg_a, fd_a);
        rst = 1'b0;
        edges = 0;
        for (int k = 0; k < 17; k++) begin
            tick(1);
            ph = edges - 1; cnt = ph % 4; idx = (ph / 4) % 4;
            esel = (cnt == 0) ? 4'h0 : (4'h1 << idx);
            es   = (cnt == 0) ? 7'h00 : 7'h3F;
            total++; if (sel_a !== esel) begin bad++; $display("FAIL rmid_scan_sel e=%0d got=%b want=%b", edges, sel_a, esel); end
            total++; if (seg_a !== es) begin bad++; $display("FAIL rmid_scan_seg e=%0d got=%h want=%h", edges, seg_a, es); end
            total++; if (dp_a !== 1'b0) begin bad++; $display("FAIL rmid_scan_dp e=%0d got=%b want=0", edges, dp_a); end
            total++; if (fd_a !== (edges == 16)) begin bad++; $display("FAIL rmid_fd e=%0d got=%b want=%b", edges, fd_a, edges == 16); end
            $display("reset_mid: e=%0d sel=%b seg=%h fd=%b", edges, sel_a, seg_a, fd_a);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_lz();
        test_load_wrap();
        test_blank();
        test_active_low();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seven_seg_scan_mux.md
Name: seven_seg_scan_mux

Overview:
- Parametrised time-multiplexed driver for an N-digit common-select seven-segment display.
- Latches a packed hex value and decimal points on a load strobe, then scans the digits in turn using a programmable refresh prescaler.
- Inserts a ghost-blanking gap between digits and can suppress leading zeros.
- Sits between datapath results (e.g. multiplier output) and the board display pins; it is the multi-digit successor of the two-digit scanner.

Parameters:
- NUM_DIGITS, 4, digits scanned; legal 2..8.
- REFRESH_DIV, 100000, clk cycles each digit is selected; legal >= 2.
- BLANK_CYCLES, 16, cycles at the start of each digit slot with all selects inactive; legal 0..REFRESH_DIV-1.
- LZ_SUPPRESS, 0, 1 = blank leading zero digits.
- SEG_ACTIVE_LOW, 1, 1 = seg/dp pins driven low to light.
- SEL_ACTIVE_LOW, 1, 1 = dig_sel pins driven low to enable a digit.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous reset, active-high.
- load  input  1  capture value_in/dp_in into shadow registers this cycle.
- value_in  input  4*NUM_DIGITS  packed nibbles; nibble i ([4i+3:4i]) is digit i; digit 0 is least significant.
- dp_in  input  NUM_DIGITS  decimal point per digit.
- blank  input  1  1 = force all digits dark (scan continues).
- seg  output  7  segments; seg[0]=a … seg[6]=g.
- dp  output  1  decimal point of the selected digit.
- dig_sel  output  NUM_DIGITS  one-hot digit enable (polarity per SEL_ACTIVE_LOW).
- frame_done  output  1  one-cycle pulse when the last digit's slot ends.

Behaviour:
- Reset (rst=1 at an edge):
  - Prescaler, digit index and shadow value/dp all cleared to 0.
  - seg/dp driven to the unlit level; dig_sel all inactive; frame_done=0.
  - Reset mid-scan abandons the current slot; the next slot after release is digit 0 with a full REFRESH_DIV count.
- Prescaler: counts 0..REFRESH_DIV-1 and wraps.
  - At count REFRESH_DIV-1 the digit index advances 0→1→…→NUM_DIGITS-1→0.
  - frame_done=1 in the cycle after the index wraps N-1→0, for exactly 1 cycle.
- Shadow load:
  - load=1 at edge k → shadow updated at edge k; outputs reflect it from edge k+1 (2-cycle latency from load assertion to pins).
  - load does not disturb prescaler or index.
  - Repeated loads take the last value.
- Registered outputs: all outputs are registered and computed each cycle from the current prescaler count, index and shadow.
- Blanking gap: while prescaler count < BLANK_CYCLES, dig_sel is all inactive and seg/dp are unlit. Otherwise dig_sel[index] is active and all other bits inactive.
- Hex decode, seg[6:0] active-high codes:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - Invert seg and dp when SEG_ACTIVE_LOW=1; invert dig_sel when SEL_ACTIVE_LOW=1.
- Leading-zero suppression (LZ_SUPPRESS=1):
  - Digit i>0 is dark (seg unlit) if shadow nibbles i..N-1 are all zero.
  - Digit 0 is never suppressed.
  - dp still follows dp_in of that digit.
  - dig_sel is still asserted for a suppressed digit.
- blank=1: seg and dp unlit; dig_sel follows normal scan. Takes effect 1 cycle after sampling.
- Simultaneous load and index advance: the new value is used by the next digit slot with normal latency, with no glitch on the non-selected digits.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1, both polarities active-high unless stated):
- Reset, then load value_in=16'h1A3F, dp_in=0 → dig_sel sequence per slot: 0000 for 1 cycle, then 0001 for 3 cycles with seg=71; then digit1 seg=4F, digit2 seg=77, digit3 seg=06. frame_done pulses once every 16 cycles.
- LZ_SUPPRESS=1, load 16'h0005 → digits 3..1 seg=00 with dig_sel still stepping; digit 0 seg=6D. Load 16'h0000 → digit 0 seg=3F, others dark.
- load pulsed at the edge where the prescaler wraps, digit 1→2 → new nibble visible on digit 2 exactly 2 cycles after the load edge; the earlier digit 1 output is unaffected.
- blank=1 for 10 cycles mid-frame → seg=00, dp=0 throughout while dig_sel keeps scanning; values resume unchanged 1 cycle after blank drops.
- SEG_ACTIVE_LOW=1, SEL_ACTIVE_LOW=1, digit showing 8 with dp_in=1 → seg=00, dp=0, selected dig_sel bit 0, others 1. During the gap, dig_sel=1111 and seg=7F.
- Assert rst for 1 cycle while index=2, prescaler=2 → next edge: dig_sel inactive, shadow 0. Scan restarts at digit 0 and the first frame_done arrives 16 cycles after reset release.
